// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between instruction fetch and the load/store queue.
// Round-robin on ties, one transaction in flight, all memory-side outputs
// come straight from registers latched at grant time. A flush abandons the
// in-flight transaction from the requester's point of view. The memory
// access itself still completes (DRAIN) so the memory never sees an abort.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read,
  input  logic [15:0] if_address,
  output logic        if_resp,
  output logic [15:0] if_rdata,
  input  logic        lsq_read,
  input  logic        lsq_write,
  input  logic [15:0] lsq_address,
  input  logic [15:0] lsq_wdata,
  input  logic [1:0]  lsq_wmask,
  output logic        lsq_resp,
  output logic [15:0] lsq_rdata,
  input  logic        flush,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_LSQ = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_lsq_q, last_lsq_d;   // 1: last grant went to the LSQ
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  wmask_q, wmask_d;

  logic lsq_req;
  assign lsq_req = lsq_read | lsq_write;

  // Memory side is driven only from the latched transaction registers.
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign busy        = (state_q != IDLE);

  // Read data is shared; only the response strobe tells whose it is.
  assign if_rdata  = mem_rdata;
  assign lsq_rdata = mem_rdata;

  // Next-state, grant and response logic.
  always_comb begin
    state_d    = state_q;
    last_lsq_d = last_lsq_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_resp    = 1'b0;
    lsq_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        // A flush here means the pending requests are stale: grant nothing.
        if (!flush) begin
          if (if_read && (!lsq_req || last_lsq_q)) begin
            state_d    = SERVE_IF;
            last_lsq_d = 1'b0;
            rd_d       = 1'b1;
            wr_d       = 1'b0;
            addr_d     = if_address;
            wdata_d    = 16'h0000;
            wmask_d    = 2'b00;
          end else if (lsq_req) begin
            state_d    = SERVE_LSQ;
            last_lsq_d = 1'b1;
            rd_d       = lsq_read;
            wr_d       = lsq_write;
            addr_d     = lsq_address;
            wdata_d    = lsq_wdata;
            wmask_d    = lsq_wmask;
          end
        end
      end
      SERVE_IF, SERVE_LSQ: begin
        if (mem_resp) begin
          // Flush on the completion cycle still kills the response.
          if (state_q == SERVE_IF) if_resp  = !flush && !reset;
          else                     lsq_resp = !flush && !reset;
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_lsq_q <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      wmask_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_lsq_q <= last_lsq_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model:
// the model tracks who owns the port, whether the owner was flushed, and who
// was granted last, and derives every expected output from those facts.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_read;
  logic [15:0] if_address;
  logic        if_resp;
  logic [15:0] if_rdata;
  logic        lsq_read, lsq_write;
  logic [15:0] lsq_address, lsq_wdata;
  logic [1:0]  lsq_wmask;
  logic        lsq_resp;
  logic [15:0] lsq_rdata;
  logic        flush;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_address(if_address),
    .if_resp(if_resp), .if_rdata(if_rdata),
    .lsq_read(lsq_read), .lsq_write(lsq_write),
    .lsq_address(lsq_address), .lsq_wdata(lsq_wdata), .lsq_wmask(lsq_wmask),
    .lsq_resp(lsq_resp), .lsq_rdata(lsq_rdata),
    .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = IF, 2 = LSQ.
  int          m_owner;
  bit          m_drop;      // owner was flushed, completion will be silent
  bit          m_last_lsq;
  bit          m_fresh;     // nothing granted since reset, fields must be zero
  bit          m_rd, m_wr;
  logic [15:0] m_addr, m_wdata;
  logic [1:0]  m_wmask;

  bit          e_if_resp, e_lsq_resp, e_busy;
  bit          if_done, lsq_done, pick_if, lsq_req;

  initial begin
    reset = 1'b1; if_read = 0; if_address = 0; lsq_read = 0; lsq_write = 0;
    lsq_address = 0; lsq_wdata = 0; lsq_wmask = 0; flush = 0;
    mem_resp = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  {15'd0, busy},      16'd0);
    check_eq("rst_rd",    {15'd0, mem_read},  16'd0);
    check_eq("rst_wr",    {15'd0, mem_write}, 16'd0);
    check_eq("rst_addr",  mem_address,        16'd0);
    check_eq("rst_wdata", mem_wdata,          16'd0);
    check_eq("rst_wmask", {14'd0, mem_wmask}, 16'd0);
    check_eq("rst_ifr",   {15'd0, if_resp},   16'd0);
    check_eq("rst_lsqr",  {15'd0, lsq_resp},  16'd0);

    m_owner = 0; m_drop = 0; m_last_lsq = 1; m_fresh = 1;
    m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_wmask = 0;
    if_done = 0; lsq_done = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Drive this cycle's inputs.
      reset = ($urandom_range(0, 99) == 0);
      if (if_done) if_read = 1'b0;
      if (!if_read && $urandom_range(0, 2) == 0) begin
        if_read    = 1'b1;
        if_address = 16'($urandom);
      end
      if (lsq_done) begin lsq_read = 1'b0; lsq_write = 1'b0; end
      if (!lsq_read && !lsq_write && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) lsq_read = 1'b1; else lsq_write = 1'b1;
        lsq_address = 16'($urandom);
        lsq_wdata   = 16'($urandom);
        lsq_wmask   = 2'($urandom);
      end
      flush     = ($urandom_range(0, 9) == 0);
      mem_resp  = (m_owner != 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      #1;

      // Expected outputs this cycle.
      e_busy     = (m_owner != 0);
      e_if_resp  = (m_owner == 1) && !m_drop && mem_resp && !flush && !reset;
      e_lsq_resp = (m_owner == 2) && !m_drop && mem_resp && !flush && !reset;
      check_eq("busy",     {15'd0, busy},      {15'd0, e_busy});
      check_eq("mem_read", {15'd0, mem_read},  {15'd0, e_busy && m_rd});
      check_eq("mem_write",{15'd0, mem_write}, {15'd0, e_busy && m_wr});
      check_eq("if_resp",  {15'd0, if_resp},   {15'd0, e_if_resp});
      check_eq("lsq_resp", {15'd0, lsq_resp},  {15'd0, e_lsq_resp});
      if (e_busy || m_fresh) begin
        check_eq("mem_address", mem_address,        m_addr);
        check_eq("mem_wdata",   mem_wdata,          m_wdata);
        check_eq("mem_wmask",   {14'd0, mem_wmask}, {14'd0, m_wmask});
      end
      if (e_if_resp)  check_eq("if_rdata",  if_rdata,  mem_rdata);
      if (e_lsq_resp) check_eq("lsq_rdata", lsq_rdata, mem_rdata);
      if_done  = e_if_resp;
      lsq_done = e_lsq_resp;

      // Advance the model to what the next edge should produce.
      lsq_req = lsq_read || lsq_write;
      if (reset) begin
        m_owner = 0; m_drop = 0; m_last_lsq = 1; m_fresh = 1;
        m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_wmask = 0;
      end else if (m_owner == 0) begin
        if (!flush && (if_read || lsq_req)) begin
          pick_if = (if_read && lsq_req) ? m_last_lsq : if_read;
          m_fresh = 0;
          m_drop  = 0;
          if (pick_if) begin
            m_owner = 1; m_last_lsq = 0; m_rd = 1; m_wr = 0;
            m_addr = if_address; m_wdata = 0; m_wmask = 0;
          end else begin
            m_owner = 2; m_last_lsq = 1; m_rd = lsq_read; m_wr = lsq_write;
            m_addr = lsq_address; m_wdata = lsq_wdata; m_wmask = lsq_wmask;
          end
        end
      end else if (mem_resp) begin
        n_txn++;
        $display("txn %0d: %s %s addr=%h wdata=%h wmask=%b rdata=%h %s", n_txn,
                 (m_owner == 1) ? "IF " : "LSQ", m_wr ? "WR" : "RD", m_addr,
                 m_wdata, m_wmask, mem_rdata,
                 (m_drop || flush) ? "flushed" : "delivered");
        m_owner = 0;
        m_drop  = 0;
      end else if (flush) begin
        m_drop = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: if_read  input  1  instruction-fetch read request, level-held until if_resp.
REQ-004: if_address  input  16  fetch word address.
REQ-005: if_resp  output  1  one-cycle fetch completion.
REQ-006: if_rdata  output  16  fetch read data, valid when if_resp=1.
REQ-007: lsq_read / lsq_write  input  1 each  load/store queue request, level-held until lsq_resp; never both 1.
REQ-008: lsq_address  input  16;  lsq_wdata  input  16;  lsq_wmask  input  2  LSQ request fields.
REQ-009: lsq_resp  output  1;  lsq_rdata  output  16  LSQ completion and read data.
REQ-010: flush  input  1  pipeline flush (mispredict); abandons the in-flight transaction.
REQ-011: mem_read / mem_write  output  1 each  shared memory port strobes.
REQ-012: mem_address  output  16;  mem_wdata  output  16;  mem_wmask  output  2  shared port fields.
REQ-013: mem_resp  input  1;  mem_rdata  input  16  memory completion and read data.
REQ-014: busy  output  1  high whenever state != IDLE.

Function
REQ-015: FSM states: IDLE, SERVE_IF, SERVE_LSQ, DRAIN.
REQ-016: IDLE samples requests each edge; if_read alone -> SERVE_IF; lsq_read|lsq_write alone -> SERVE_LSQ; none -> stay IDLE.
REQ-017: Both requesting in IDLE -> grant the requester NOT granted last (round-robin); last_grant register updates on every grant.
REQ-018: On grant, latch owner's address, wdata, wmask, read/write into registers; mem_* outputs driven only from these registers (no combinational path from requester inputs to mem_*).
REQ-019: Grant latency: request sampled at edge N -> mem_read/mem_write high in cycle N+1.
REQ-020: IF grant: mem_read=1, mem_write=0, mem_wmask=2'b00, mem_address=if_address latched.
REQ-021: LSQ grant: mem_read=lsq_read, mem_write=lsq_write, fields as latched; address and mask passed unmodified.
REQ-022: mem_* held constant in SERVE_IF/SERVE_LSQ/DRAIN until mem_resp.
REQ-023: In SERVE_x with mem_resp=1: owner's *_resp=1 and *_rdata=mem_rdata combinationally that cycle; next state IDLE; mem_read/mem_write low next cycle.
REQ-024: Non-owner resp always 0; *_rdata drives mem_rdata unconditionally (qualified only by resp).
REQ-025: Requests are not sampled in the cycle mem_resp=1; IDLE re-arbitrates from the following edge (min 1 idle cycle between transactions).
REQ-026: flush in SERVE_x without mem_resp -> DRAIN; mem_* stay asserted and unchanged (memory transaction never aborted mid-flight).
REQ-027: DRAIN with mem_resp=1 -> IDLE; if_resp and lsq_resp stay 0 throughout DRAIN.
REQ-028: flush coincident with mem_resp in SERVE_x -> IDLE, resp suppressed (flush wins).
REQ-029: flush in IDLE -> no grant that edge; stay IDLE.
REQ-030: flush in DRAIN has no additional effect.
REQ-031: Requester deasserting before resp is a protocol violation; arbiter ignores it and completes on mem_resp.

Reset
REQ-032: reset forces IDLE, last_grant=LSQ (so IF wins first tie), all latched fields 0.
REQ-033: During/after reset: mem_read=0, mem_write=0, mem_wmask=0, mem_address=0, mem_wdata=0, if_resp=0, lsq_resp=0, busy=0.
REQ-034: reset mid-transaction returns to IDLE next edge with strobes low; no resp issued for the dropped transaction.

Verification
REQ-035: if_read=1, addr 0x0040; mem_resp after 3 cycles with rdata 0x1234 -> mem_read high 3 cycles at 0x0040, if_resp=1 with if_rdata=0x1234 for 1 cycle, lsq_resp=0.
REQ-036: After reset, if_read and lsq_read both held -> IF served first, then LSQ, then IF again (alternation over 3 transactions, 1 idle cycle between each).
REQ-037: lsq_write addr 0x2001, wdata 0x00AB, wmask 2'b10 -> mem_write=1 with exactly those values held until mem_resp; lsq_resp pulses once.
REQ-038: flush 1 cycle after LSQ read grant, mem_resp 4 cycles later -> mem_read held until mem_resp, lsq_resp never asserted, busy drops the cycle after mem_resp.
REQ-039: flush and mem_resp in same cycle during SERVE_IF -> if_resp=0, state IDLE next cycle.
REQ-040: reset asserted during SERVE_LSQ write -> next cycle mem_write=0, busy=0, lsq_resp=0.
